gate_checker: RTL and testbench
===============================

# gate_checker

Synthesizable response checker for the two-input gate blocks. It is the receiving end of the gate test flow: a stimulus source presents (a, b) vectors over a valid/ready handshake. The checker waits a programmable settle time, then samples the DUT output and compares it against the expected value for a selected gate function. It accumulates check and error counts, captures the first failing vector, and reports pass/fail.

## Interface
- SETTLE_CYCLES, 2: cycles between vector acceptance and `dut_y` sampling; legal range ≥1.
- CNT_W, 16: width of the vector-count, check-count, error-count and index fields.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  run request; honoured only in IDLE or DONE.
- func  in  3  expected function, latched on start: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a, 111 BUF a.
- num_vec  in  CNT_W  vectors in this run, latched on start.
- vec_valid  in  1  stimulus vector valid.
- vec_ready  out  1  checker can accept a vector.
- vec_a, vec_b  in  1 each  stimulus vector bits.
- dut_y  in  1  DUT output under check.
- busy  out  1  high in WAIT_VEC or SETTLE.
- done  out  1  high in DONE.
- pass  out  1  meaningful while done=1; equals err_cnt==0.
- chk_cnt  out  CNT_W  vectors checked in this run.
- err_cnt  out  CNT_W  mismatches; saturates at all-ones.
- first_err_vec  out  2  {a,b} of the first mismatch.
- first_err_y  out  1  dut_y observed at the first mismatch.
- first_err_idx  out  CNT_W  0-based index of the first mismatch.

## Operation
- States: IDLE, WAIT_VEC, SETTLE, DONE.
- Reset (rst_n=0 at an edge) sets:
  - state IDLE;
  - vec_ready, busy, done, pass = 0;
  - all counters and first_err_* fields = 0;
  - internal latches (func, num_vec, captured vector) = 0.
- IDLE or DONE, start=1 at an edge:
  - latch func and num_vec;
  - clear chk_cnt, err_cnt and all first_err_* fields;
  - go to WAIT_VEC, or to DONE if num_vec==0 (pass=1).
- WAIT_VEC:
  - vec_ready=1;
  - an edge with vec_valid=1 accepts the vector: capture vec_a/vec_b, load the settle counter with SETTLE_CYCLES, go to SETTLE;
  - vec_valid=0 stalls indefinitely.
- SETTLE:
  - vec_ready=0; the settle counter decrements each edge;
  - on the edge where the counter expires, sample dut_y and compare with expected(func, captured a, captured b);
  - chk_cnt increments;
  - on mismatch, err_cnt increments (saturating); if err_cnt was 0, also load first_err_vec, first_err_y and first_err_idx (= pre-increment chk_cnt);
  - next state is DONE if the new chk_cnt == latched num_vec, otherwise WAIT_VEC.
- DONE:
  - done=1 and pass=(err_cnt==0), both held until start or reset;
  - counters and first_err_* fields are stable.
- start while busy is ignored. Vector inputs outside WAIT_VEC are ignored.
- func changes after start do not affect the run in progress.

## Timing
- All outputs are registered; no combinational input-to-output paths (vec_ready decodes from the state register).
- start sampled at edge t: vec_ready=1 from t+1 (num_vec>0), or done=1 and pass=1 from t+1 (num_vec==0).
- Vector accepted at edge k: dut_y sampled at edge k+SETTLE_CYCLES. The counter and first_err_* updates, and done if this was the last vector, are visible after that edge.
- vec_ready reasserts at k+SETTLE_CYCLES unless the run is complete.
- Throughput: one vector per SETTLE_CYCLES+1 cycles with vec_valid held high.
- Reset mid-SETTLE discards the pending sample, with no counter update; the state after that edge is IDLE.
- A reset edge overrides start in the same cycle.
- chk_cnt does not saturate; num_vec bounds it.

## Test plan
- Clean NAND run, SETTLE_CYCLES=2:
  - stimulus: func=010, num_vec=4; vectors 00,01,10,11 with the DUT returning 1,1,1,0;
  - required response: done=1, pass=1, chk_cnt=4, err_cnt=0, and exactly 3 cycles between successive vec_ready rises.
- Injected fault:
  - stimulus: same run, but dut_y forced to 1 on vector 11 (index 3);
  - required response: err_cnt=1, pass=0, first_err_vec=2'b11, first_err_y=1, first_err_idx=3.
- Two faults:
  - stimulus: XOR run, func=100, with the DUT returning wrong values at indices 1 and 2;
  - required response: err_cnt=2, first_err_idx=1 (not overwritten by the second fault).
- Zero-length run:
  - stimulus: num_vec=0, start pulse;
  - required response: done=1, pass=1 one cycle later; vec_ready never asserts.
- Stall and ignored start:
  - stimulus: vec_valid low for 10 cycles in WAIT_VEC; start pulsed during SETTLE;
  - required response: no progress during the stall; func and num_vec unchanged; the run completes normally.
- Reset mid-SETTLE, then restart from DONE:
  - stimulus: rst_n=0 for 1 cycle during SETTLE; then start a new run from DONE;
  - required response: reset gives IDLE with all outputs 0; the new run clears counters on the start edge.

Source files
------------

// File: rtl/gate_checker.sv
// gate_checker: handshake-driven response checker for two-input gate blocks.
// Settles, samples dut_y, compares against the selected gate and tallies errors.
module gate_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       first_err_vec,
  output logic             first_err_y,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [2:0]       r_func;
  logic [CNT_W-1:0] r_num;
  logic             r_a;
  logic             r_b;
  logic [SW-1:0]    r_cnt;
  logic             r_pass;
  logic [CNT_W-1:0] r_chk;
  logic [CNT_W-1:0] r_err;
  logic [1:0]       r_fvec;
  logic             r_fy;
  logic [CNT_W-1:0] r_fidx;

  logic             w_exp;
  logic             w_mis;
  logic [CNT_W-1:0] w_chk_nxt;

  always_comb begin
    w_exp = 1'b0;
    unique case (r_func)
      3'b000: w_exp = r_a & r_b;
      3'b001: w_exp = r_a | r_b;
      3'b010: w_exp = ~(r_a & r_b);
      3'b011: w_exp = ~(r_a | r_b);
      3'b100: w_exp = r_a ^ r_b;
      3'b101: w_exp = ~(r_a ^ r_b);
      3'b110: w_exp = ~r_a;
      3'b111: w_exp = r_a;
      default: w_exp = 1'b0;
    endcase
  end

  assign w_mis     = dut_y != w_exp;
  assign w_chk_nxt = r_chk + 1'b1;

  assign vec_ready     = r_state == S_WAIT;
  assign busy          = (r_state == S_WAIT) || (r_state == S_SETTLE);
  assign done          = r_state == S_DONE;
  assign pass          = r_pass;
  assign chk_cnt       = r_chk;
  assign err_cnt       = r_err;
  assign first_err_vec = r_fvec;
  assign first_err_y   = r_fy;
  assign first_err_idx = r_fidx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_func  <= '0;
      r_num   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
      r_chk   <= '0;
      r_err   <= '0;
      r_fvec  <= '0;
      r_fy    <= 1'b0;
      r_fidx  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_func <= func;
            r_num  <= num_vec;
            r_chk  <= '0;
            r_err  <= '0;
            r_fvec <= '0;
            r_fy   <= 1'b0;
            r_fidx <= '0;
            if (num_vec == '0) begin
              r_state <= S_DONE;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_pass  <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (vec_valid) begin
            r_a     <= vec_a;
            r_b     <= vec_b;
            r_cnt   <= SW'(SETTLE_CYCLES);
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SW'(1)) begin
            r_chk <= w_chk_nxt;
            if (w_mis) begin
              if (r_err != '1) r_err <= r_err + 1'b1;
              // only the first mismatch of a run is captured
              if (r_err == '0) begin
                r_fvec <= {r_a, r_b};
                r_fy   <= dut_y;
                r_fidx <= r_chk;
              end
            end
            if (w_chk_nxt == r_num) begin
              r_state <= S_DONE;
              r_pass  <= !(w_mis || (r_err != '0));
            end else begin
              r_state <= S_WAIT;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: randomized and directed checks of gate_checker
// against a cycle-counting behavioural model.
module tb_gate_checker;

  localparam int S = 2;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   func = '0;
  logic [W-1:0] num_vec = '0;
  logic         vec_valid = 1'b0;
  logic         vec_a = 1'b0;
  logic         vec_b = 1'b0;
  logic         dut_y = 1'b0;
  logic         vec_ready;
  logic         busy;
  logic         done;
  logic         pass;
  logic [W-1:0] chk_cnt;
  logic [W-1:0] err_cnt;
  logic [1:0]   first_err_vec;
  logic         first_err_y;
  logic [W-1:0] first_err_idx;

  gate_checker #(.SETTLE_CYCLES(S), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func),
    .num_vec(num_vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .dut_y(dut_y), .busy(busy),
    .done(done), .pass(pass), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .first_err_vec(first_err_vec), .first_err_y(first_err_y),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit m_run, m_done, m_pass, m_pend;
  int m_func, m_num, m_chk, m_err, m_fv, m_fy, m_fi, m_acc, m_pa, m_pb;

  bit prev_rdy = 1'b0;
  int rises[$];

  bit [15:0] flip;
  bit [1:0]  vv[16];
  bit        use_vv;

  function automatic bit gate(input int f, input bit a, input bit b);
    case (f)
      0: return a & b;
      1: return a | b;
      2: return !(a & b);
      3: return !(a | b);
      4: return a ^ b;
      5: return !(a ^ b);
      6: return !a;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // applies the effect of the edge just taken, using the pre-edge inputs
  task automatic model_update();
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_pass = 0; m_pend = 0;
      m_func = 0; m_num = 0; m_chk = 0; m_err = 0;
      m_fv = 0; m_fy = 0; m_fi = 0;
    end else if (!m_run && start) begin
      m_func = int'(func); m_num = int'(num_vec);
      m_chk = 0; m_err = 0; m_fv = 0; m_fy = 0; m_fi = 0; m_pend = 0;
      if (num_vec == 0) begin
        m_done = 1; m_pass = 1; m_run = 0;
      end else begin
        m_run = 1; m_done = 0; m_pass = 0;
      end
    end else if (m_run) begin
      if (m_pend && cyc == m_acc + S) begin
        m_pend = 0;
        if (dut_y != gate(m_func, m_pa[0], m_pb[0])) begin
          if (m_err == 0) begin
            m_fv = m_pa * 2 + m_pb; m_fy = int'(dut_y); m_fi = m_chk;
          end
          if (m_err < 65535) m_err++;
        end
        m_chk++;
        if (m_chk == m_num) begin
          m_run = 0; m_done = 1; m_pass = (m_err == 0);
        end
      end else if (!m_pend && vec_valid) begin
        m_pend = 1; m_acc = cyc;
        m_pa = int'(vec_a); m_pb = int'(vec_b);
      end
    end
  endtask

  task automatic compare_all();
    check("vec_ready", 32'(vec_ready), 32'(m_run && !m_pend));
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
    check("pass", 32'(pass), 32'(m_pass));
    check("chk_cnt", 32'(chk_cnt), m_chk);
    check("err_cnt", 32'(err_cnt), m_err);
    check("first_err_vec", 32'(first_err_vec), m_fv);
    check("first_err_y", 32'(first_err_y), m_fy);
    check("first_err_idx", 32'(first_err_idx), m_fi);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    compare_all();
    if (vec_ready && !prev_rdy) rises.push_back(cyc);
    prev_rdy = vec_ready;
  endtask

  task automatic pulse_start(input int f, input int n);
    start = 1; func = 3'(f); num_vec = W'(n); vec_valid = 0;
    step();
    start = 0; func = 3'($urandom); num_vec = W'($urandom);
  endtask

  task automatic drive(input int f, input int n, input int idx0,
                       input int stall_pct, input bit noise);
    int idx = idx0;
    int guard = 0;
    while (!done && guard < 400) begin
      if (vec_ready && idx < n && $urandom_range(99) >= stall_pct) begin
        vec_valid = 1;
        if (use_vv) {vec_a, vec_b} = vv[idx];
        else {vec_a, vec_b} = 2'($urandom);
        dut_y = gate(f, vec_a, vec_b) ^ flip[idx];
        idx++;
      end else if (!vec_ready && noise) begin
        vec_valid = 1'($urandom);
        vec_a = 1'($urandom); vec_b = 1'($urandom);
        start = ($urandom_range(9) == 0);
        func = 3'($urandom);
      end else begin
        vec_valid = 0;
      end
      step();
      start = 0;
      guard++;
    end
    vec_valid = 0;
    check("run_completes", 32'(done), 32'd1);
  endtask

  initial begin
    int n, f;
    flip = '0; use_vv = 1;
    vv[0] = 2'b00; vv[1] = 2'b01; vv[2] = 2'b10; vv[3] = 2'b11;

    rst_n = 0;
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(vec_ready), 0);
    rst_n = 1;
    step();

    // clean NAND run, back-to-back vectors
    rises.delete();
    pulse_start(2, 4);
    drive(2, 4, 0, 0, 0);
    check("nand_pass", 32'(pass), 1);
    check("nand_chk", 32'(chk_cnt), 4);
    check("nand_err", 32'(err_cnt), 0);
    check("nand_rises", rises.size(), 4);
    for (int i = 1; i < rises.size(); i++)
      check("ready_spacing", rises[i] - rises[i-1], S + 1);

    // fault on vector 11
    flip = 16'b1000;
    pulse_start(2, 4);
    drive(2, 4, 0, 0, 0);
    check("flt_err", 32'(err_cnt), 1);
    check("flt_pass", 32'(pass), 0);
    check("flt_vec", 32'(first_err_vec), 3);
    check("flt_y", 32'(first_err_y), 1);
    check("flt_idx", 32'(first_err_idx), 3);

    // two faults on XOR
    flip = 16'b0110;
    pulse_start(4, 4);
    drive(4, 4, 0, 0, 0);
    check("xor_err", 32'(err_cnt), 2);
    check("xor_idx", 32'(first_err_idx), 1);
    check("xor_vec", 32'(first_err_vec), 1);
    flip = '0;

    // zero-length run
    pulse_start(0, 0);
    check("zero_done", 32'(done), 1);
    check("zero_pass", 32'(pass), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("zero_ready", 32'(vec_ready), 0);
    end

    // stall, then start pulsed during SETTLE
    pulse_start(5, 2);
    for (int i = 0; i < 10; i++) step();
    check("stall_chk", 32'(chk_cnt), 0);
    check("stall_ready", 32'(vec_ready), 1);
    vec_valid = 1; vec_a = 1; vec_b = 0; dut_y = gate(5, 1, 0);
    step();
    vec_valid = 0; start = 1; func = 0; num_vec = 7; vec_a = 0;
    step();
    start = 0;
    drive(5, 2, 1, 0, 0);
    check("stall_run_chk", 32'(chk_cnt), 2);
    check("stall_run_pass", 32'(pass), 1);

    // reset in SETTLE after one checked vector
    pulse_start(2, 4);
    vec_valid = 1; vec_a = 0; vec_b = 0; dut_y = 1;
    step();
    vec_valid = 0;
    step(); step();
    check("pre_rst_chk", 32'(chk_cnt), 1);
    vec_valid = 1; vec_a = 1; vec_b = 1; dut_y = 1;
    step();
    vec_valid = 0; rst_n = 0;
    step();
    check("mid_rst_chk", 32'(chk_cnt), 0);
    check("mid_rst_err", 32'(err_cnt), 0);
    check("mid_rst_busy", 32'(busy), 0);
    start = 1; num_vec = 3;
    step();
    check("rst_over_start", 32'(busy), 0);
    rst_n = 1; start = 0;
    step();

    // run with an error, then restart from DONE
    flip = 16'b1;
    pulse_start(3, 3);
    drive(3, 3, 0, 0, 0);
    check("pre_restart_err", 32'(err_cnt), 1);
    flip = '0;
    pulse_start(1, 3);
    check("restart_chk", 32'(chk_cnt), 0);
    check("restart_err", 32'(err_cnt), 0);
    check("restart_ready", 32'(vec_ready), 1);
    drive(1, 3, 0, 0, 0);
    check("restart_pass", 32'(pass), 1);

    // randomized runs
    use_vv = 0;
    for (int r = 0; r < 40; r++) begin
      f = $urandom_range(7);
      n = $urandom_range(12, 1);
      flip = ($urandom_range(2) == 0) ? 16'($urandom) : '0;
      pulse_start(f, n);
      drive(f, n, 0, 30, 1);
      for (int k = 0; k < $urandom_range(3); k++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
